// File: rtl/lut_pkg.sv
// Shared definitions for the LUT programming path: op encodings, default
// widths, writer state encoding and the reference operation function.
package lut_pkg;

  localparam int LUT_ADDR_W = 4;
  localparam int LUT_DATA_W = 2;

  localparam logic [1:0] OP_AND  = 2'd0;
  localparam logic [1:0] OP_OR   = 2'd1;
  localparam logic [1:0] OP_XOR  = 2'd2;
  localparam logic [1:0] OP_NAND = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_VERIFY = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } lut_state_t;

  // Bitwise 2-input op; the result is already LUT_DATA_W wide, so NAND
  // needs no extra masking.
  function automatic logic [LUT_DATA_W-1:0] lut_func(
    input logic [1:0]            op,
    input logic [LUT_DATA_W-1:0] a,
    input logic [LUT_DATA_W-1:0] b
  );
    logic [LUT_DATA_W-1:0] y;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = ~(a & b);
    endcase
    return y;
  endfunction

endpackage

// File: rtl/lut_writer_if.sv
// LUT RAM port bundle between the writer (master) and the RAM (slave).
//
// Handshake: there is no valid/ready pair on this bus. wr_en is a one-cycle
// write strobe qualifying wr_addr/wr_data, sampled by the RAM on the rising
// edge. Reads are unconditional: rd_data returns mem[rd_addr] exactly one
// cycle after rd_addr is presented, with no back-pressure.
interface lut_writer_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 2
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (output wr_en, wr_addr, wr_data, rd_addr, input rd_data);
  modport slave  (input wr_en, wr_addr, wr_data, rd_addr, output rd_data);
endinterface

// File: rtl/lut_op.sv
// Combinational op evaluator: one LUT entry value from op and the two
// address halves.
module lut_op
  import lut_pkg::*;
(
  input  logic [1:0]            op,
  input  logic [LUT_DATA_W-1:0] a,
  input  logic [LUT_DATA_W-1:0] b,
  output logic [LUT_DATA_W-1:0] y
);
  assign y = lut_func(op, a, b);
endmodule

// File: rtl/lut_ram.sv
// 16x2 LUT storage: synchronous write, registered read. Contents are not
// reset, so an abandoned programming run leaves a partial table.
module lut_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 2
) (
  input logic         clk,
  input logic         rst_n,
  lut_writer_if.slave lut
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write port
  always_ff @(posedge clk) begin
    if (lut.wr_en) mem[lut.wr_addr] <= lut.wr_data;
  end

  // Registered read port, one cycle of latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lut.rd_data <= '0;
    else        lut.rd_data <= mem[lut.rd_addr];
  end
endmodule

// File: rtl/lut_writer.sv
// Fills the LUT RAM with f(op, addr[3:2], addr[1:0]) one entry per cycle,
// then optionally reads every entry back and counts mismatches.
module lut_writer
  import lut_pkg::*;
#(
  parameter int ADDR_W = LUT_ADDR_W,
  parameter int DATA_W = LUT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic              verify_en,
  lut_writer_if.master      lut,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   err_cnt,
  output lut_state_t        dbg_state
);

  lut_state_t        state, state_next;
  logic [ADDR_W-1:0] addr, addr_next;
  logic [1:0]        op_q, op_next;
  logic              ver_q, ver_next;
  logic              accept, last;
  logic [ADDR_W-1:0] cmp_addr;
  logic              cmp_en, mismatch;
  logic [DATA_W-1:0] wr_data_next, exp_data;

  logic              wr_en_d, busy_d, done_d;
  logic [ADDR_W-1:0] wr_addr_d, rd_addr_d;
  logic [DATA_W-1:0] wr_data_d;

  assign accept    = (state == S_IDLE) && start;
  assign last      = (addr == {ADDR_W{1'b1}});
  assign op_next   = accept ? op : op_q;
  assign ver_next  = accept ? verify_en : ver_q;
  assign dbg_state = state;

  // rd_data lags rd_addr by one cycle, so the entry under test is addr-1.
  // In DRAIN addr has wrapped to 0, which makes addr-1 the final entry.
  assign cmp_addr = addr - 1'b1;
  assign cmp_en   = ((state == S_VERIFY) && (addr != '0)) || (state == S_DRAIN);
  assign mismatch = cmp_en && (lut.rd_data != exp_data);

  lut_op u_wr_op (
    .op (op_next),
    .a  (addr_next[ADDR_W-1 -: DATA_W]),
    .b  (addr_next[DATA_W-1:0]),
    .y  (wr_data_next)
  );

  lut_op u_exp_op (
    .op (op_q),
    .a  (cmp_addr[ADDR_W-1 -: DATA_W]),
    .b  (cmp_addr[DATA_W-1:0]),
    .y  (exp_data)
  );

  // State register with address counter and run configuration latched at start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      addr  <= '0;
      op_q  <= '0;
      ver_q <= 1'b0;
    end else begin
      state <= state_next;
      addr  <= addr_next;
      op_q  <= op_next;
      ver_q <= ver_next;
    end
  end

  // Next-state and address sequencing
  always_comb begin
    state_next = state;
    addr_next  = addr;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_WRITE;
          addr_next  = '0;
        end
      end
      S_WRITE: begin
        addr_next = addr + 1'b1;
        if (last) state_next = ver_q ? S_VERIFY : S_DONE;
      end
      S_VERIFY: begin
        addr_next = addr + 1'b1;
        if (last) state_next = S_DRAIN;
      end
      S_DRAIN: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode from the next state so every output leaves a flop
  always_comb begin
    wr_en_d   = (state_next == S_WRITE);
    wr_addr_d = wr_en_d ? addr_next : '0;
    wr_data_d = wr_en_d ? wr_data_next : '0;
    rd_addr_d = (state_next == S_VERIFY) ? addr_next : '0;
    busy_d    = (state_next == S_WRITE) || (state_next == S_VERIFY) ||
                (state_next == S_DRAIN);
    done_d    = (state_next == S_DONE);
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut.wr_en   <= 1'b0;
      lut.wr_addr <= '0;
      lut.wr_data <= '0;
      lut.rd_addr <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      lut.wr_en   <= wr_en_d;
      lut.wr_addr <= wr_addr_d;
      lut.wr_data <= wr_data_d;
      lut.rd_addr <= rd_addr_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  // Sticky mismatch flag and count, cleared only by an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (accept) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (mismatch) begin
      err     <= 1'b1;
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_lut_writer.sv
// Bench for lut_writer driving a real lut_ram, with read-data fault injection.
module tb_lut_writer;
  import lut_pkg::*;

  localparam int AW = LUT_ADDR_W;
  localparam int DW = LUT_DATA_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'd0;
  logic          verify_en = 1'b0;
  logic          busy, done, err;
  logic [AW:0]   err_cnt;
  lut_state_t    dbg_state;

  logic [15:0]   fault_mask = 16'h0000;
  logic [AW-1:0] rd_addr_q;

  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] sb_exp;
  logic [DW-1:0]    wr_seen [16];

  int checks = 0;
  int errors = 0;

  lut_writer_if #(.ADDR_W(AW), .DATA_W(DW)) wbus ();
  lut_writer_if #(.ADDR_W(AW), .DATA_W(DW)) rbus ();

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end

  lut_writer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .verify_en (verify_en),
    .lut       (wbus),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_cnt   (err_cnt),
    .dbg_state (dbg_state)
  );

  lut_ram #(.ADDR_W(AW), .DATA_W(DW)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .lut   (rbus)
  );

  assign rbus.wr_en   = wbus.wr_en;
  assign rbus.wr_addr = wbus.wr_addr;
  assign rbus.wr_data = wbus.wr_data;
  assign rbus.rd_addr = wbus.rd_addr;
  // rd_data during a cycle belongs to the address issued the cycle before
  always @(posedge clk) rd_addr_q <= rbus.rd_addr;
  assign wbus.rd_data = fault_mask[rd_addr_q] ? '0 : rbus.rd_data;

  // ---------------- scoreboard on the write port ----------------
  always @(negedge clk) begin
    if (rst_n && wbus.wr_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got addr=%0h data=%0b, required no write",
                 wbus.wr_addr, wbus.wr_data);
      end else begin
        sb_exp = exp_q.pop_front();
        if ({wbus.wr_addr, wbus.wr_data} !== sb_exp) begin
          errors++;
          $display("FAIL wr_data: got addr=%0h data=%0b, required addr=%0h data=%0b",
                   wbus.wr_addr, wbus.wr_data, sb_exp[AW+DW-1:DW], sb_exp[DW-1:0]);
        end
      end
      wr_seen[wbus.wr_addr] = wbus.wr_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic launch(input logic [1:0] o, input logic v, input bit hold);
    logic [AW-1:0] av;
    @(negedge clk);
    for (int i = 0; i < 16; i++) wr_seen[i] = 'x;
    for (int a = 0; a < 16; a++) begin
      av = a[AW-1:0];
      exp_q.push_back({av, lut_func(o, av[AW-1 -: DW], av[DW-1:0])});
    end
    start = 1'b1;
    op = o;
    verify_en = v;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Steps cycles k0.. after the start edge; len is inclusive of the start cycle.
  task automatic wait_done(input int k0, input int poke_k, output int len,
                           output bit busy_ok, output int wr_cnt, output bit rd_nz);
    len = -1; busy_ok = 1'b1; wr_cnt = 0; rd_nz = 1'b0;
    for (int k = k0; k <= 60; k++) begin
      @(negedge clk);
      if (poke_k > 0 && k == poke_k) begin start = 1'b1; op = OP_NAND; end
      if (poke_k > 0 && k == poke_k + 1) start = 1'b0;
      if (wbus.wr_en) wr_cnt++;
      if (wbus.rd_addr != '0) rd_nz = 1'b1;
      if (done) begin
        len = k + 1;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({wbus.wr_en, wbus.wr_addr, wbus.wr_data, wbus.rd_addr, busy, done, err, err_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got wr_en=%b wr_addr=%0h wr_data=%0b rd_addr=%0h busy=%b done=%b err=%b err_cnt=%0d, required all 0",
               wbus.wr_en, wbus.wr_addr, wbus.wr_data, wbus.rd_addr, busy, done, err, err_cnt);
    end
    checks++;
    if (dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d, required %0d", dbg_state, S_IDLE);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (dbg_state !== S_IDLE || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got state=%0d busy=%b, required state=%0d busy=0",
               dbg_state, busy, S_IDLE);
    end
  endtask

  task automatic test_and_verify();
    int len, wr_cnt; bit busy_ok, rd_nz;
    launch(OP_AND, 1'b1, 1'b0);
    wait_done(1, 0, len, busy_ok, wr_cnt, rd_nz);
    checks++;
    if (len !== 35) begin errors++; $display("FAIL and_len: got %0d, required 35", len); end
    checks++;
    if (!busy_ok) begin errors++; $display("FAIL and_busy: got busy gap or busy at done, required busy high until done"); end
    checks++;
    if (wr_cnt !== 16) begin errors++; $display("FAIL and_wr_cnt: got %0d, required 16", wr_cnt); end
    checks++;
    if (err !== 1'b0 || err_cnt !== 0) begin
      errors++; $display("FAIL and_err: got err=%b err_cnt=%0d, required 0 0", err, err_cnt);
    end
    checks++;
    if (wr_seen[15] !== 2'b11 || wr_seen[6] !== 2'b00) begin
      errors++; $display("FAIL and_entries: got [F]=%0b [6]=%0b, required 11 00", wr_seen[15], wr_seen[6]);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || dbg_state !== S_IDLE) begin
      errors++; $display("FAIL and_done_pulse: got done=%b state=%0d, required done=0 state=%0d", done, dbg_state, S_IDLE);
    end
  endtask

  task automatic test_xor_write_only();
    int len, wr_cnt; bit busy_ok, rd_nz;
    launch(OP_XOR, 1'b0, 1'b0);
    wait_done(1, 0, len, busy_ok, wr_cnt, rd_nz);
    checks++;
    if (len !== 18) begin errors++; $display("FAIL xor_len: got %0d, required 18", len); end
    checks++;
    if (wr_cnt !== 16) begin errors++; $display("FAIL xor_wr_cnt: got %0d, required 16", wr_cnt); end
    checks++;
    if (rd_nz) begin errors++; $display("FAIL xor_rd_addr: got nonzero rd_addr, required 0 throughout"); end
    checks++;
    if (wr_seen[9] !== 2'b11) begin errors++; $display("FAIL xor_entry9: got %0b, required 11", wr_seen[9]); end
  endtask

  task automatic test_fault();
    int len, wr_cnt; bit busy_ok, rd_nz;
    fault_mask = 16'h0000;
    fault_mask[15] = 1'b1;
    fault_mask[5]  = 1'b1;
    launch(OP_OR, 1'b1, 1'b0);
    wait_done(1, 0, len, busy_ok, wr_cnt, rd_nz);
    fault_mask = 16'h0000;
    checks++;
    if (len !== 35) begin errors++; $display("FAIL fault_len: got %0d, required 35", len); end
    checks++;
    if (err !== 1'b1 || err_cnt !== 2) begin
      errors++; $display("FAIL fault_err: got err=%b err_cnt=%0d, required 1 2", err, err_cnt);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (err !== 1'b1 || err_cnt !== 2) begin
      errors++; $display("FAIL fault_hold: got err=%b err_cnt=%0d, required 1 2", err, err_cnt);
    end
  endtask

  task automatic test_start_ignored();
    int len, wr_cnt; bit busy_ok, rd_nz;
    launch(OP_AND, 1'b0, 1'b0);
    wait_done(1, 5, len, busy_ok, wr_cnt, rd_nz);
    op = OP_AND;
    checks++;
    if (len !== 18) begin errors++; $display("FAIL ignore_len: got %0d, required 18", len); end
    checks++;
    if (wr_seen[15] !== 2'b11 || wr_seen[0] !== 2'b00) begin
      errors++; $display("FAIL ignore_entries: got [F]=%0b [0]=%0b, required 11 00", wr_seen[15], wr_seen[0]);
    end
  endtask

  task automatic test_reset_mid_verify();
    bit found, seen_done, active;
    found = 1'b0; seen_done = 1'b0; active = 1'b0;
    launch(OP_OR, 1'b1, 1'b0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy && wbus.rd_addr == 4'd7) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rmv_reach: got no rd_addr=7 within 40 cycles, required reached"); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({wbus.wr_en, wbus.wr_addr, wbus.wr_data, wbus.rd_addr, busy, done, err, err_cnt} !== '0) begin
      errors++;
      $display("FAIL rmv_outputs: got wr_en=%b wr_addr=%0h wr_data=%0b rd_addr=%0h busy=%b done=%b err=%b err_cnt=%0d, required all 0",
               wbus.wr_en, wbus.wr_addr, wbus.wr_data, wbus.rd_addr, busy, done, err, err_cnt);
    end
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL rmv_writes: got %0d pending, required 0", exp_q.size()); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
      if (busy || wbus.wr_en) active = 1'b1;
    end
    checks++;
    if (seen_done || active || dbg_state !== S_IDLE) begin
      errors++; $display("FAIL rmv_after: got done=%b active=%b state=%0d, required 0 0 %0d", seen_done, active, dbg_state, S_IDLE);
    end
  endtask

  task automatic test_back_to_back();
    int len, wr_cnt; bit busy_ok, rd_nz;
    logic [AW-1:0] av;
    fault_mask = 16'h0000;
    fault_mask[3] = 1'b1;
    launch(OP_OR, 1'b1, 1'b1);
    wait_done(1, 0, len, busy_ok, wr_cnt, rd_nz);
    checks++;
    if (len !== 35 || err !== 1'b1 || err_cnt !== 1) begin
      errors++; $display("FAIL b2b_first: got len=%0d err=%b err_cnt=%0d, required 35 1 1", len, err, err_cnt);
    end
    fault_mask = 16'h0000;
    for (int a = 0; a < 16; a++) begin
      av = a[AW-1:0];
      exp_q.push_back({av, lut_func(OP_XOR, av[AW-1 -: DW], av[DW-1:0])});
    end
    op = OP_XOR;
    verify_en = 1'b0;
    @(negedge clk);
    checks++;
    if (dbg_state !== S_IDLE || busy !== 1'b0 || err !== 1'b1) begin
      errors++; $display("FAIL b2b_idle: got state=%0d busy=%b err=%b, required %0d 0 1", dbg_state, busy, err, S_IDLE);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || wbus.wr_en !== 1'b1 || err !== 1'b0 || err_cnt !== 0) begin
      errors++; $display("FAIL b2b_second: got busy=%b wr_en=%b err=%b err_cnt=%0d, required 1 1 0 0", busy, wbus.wr_en, err, err_cnt);
    end
    wait_done(2, 0, len, busy_ok, wr_cnt, rd_nz);
    checks++;
    if (len !== 18 || err !== 1'b0) begin
      errors++; $display("FAIL b2b_second_done: got len=%0d err=%b, required 18 0", len, err);
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_and_verify();
    test_xor_write_only();
    test_fault();
    test_start_ignored();
    test_reset_mid_verify();
    test_back_to_back();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL sb_drain: got %0d expected writes left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
